// File: rtl/timestamp_gen.sv
// Free-running acq/ms/sec time base with preset, coherent snapshot and tick pulses.
// All stamps, snapshots and pulses are registered; load overrides counting on the same edge.
module timestamp_gen #(
   parameter int unsigned CLKS_PER_TICK = 5000,
   parameter int unsigned TICKS_PER_MS  = 10,
   parameter int unsigned MS_PER_SEC    = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load,
   input  logic [3:0]  load_acq,
   input  logic [11:0] load_ms,
   input  logic [31:0] load_sec,
   input  logic        snap,
   output logic [3:0]  acqurate_stamp,
   output logic [11:0] millisecond_stamp,
   output logic [31:0] second_stamp,
   output logic [3:0]  snap_acq,
   output logic [11:0] snap_ms,
   output logic [31:0] snap_sec,
   output logic        snap_valid,
   output logic        ms_tick,
   output logic        pps,
   output logic        load_err
);

   localparam int unsigned PW       = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_TICK - 1);
   localparam logic [3:0]  ACQ_LAST = 4'(TICKS_PER_MS - 1);
   localparam logic [11:0] MS_LAST  = 12'(MS_PER_SEC - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    acq_q, acq_d;
   logic [11:0]   ms_q, ms_d;
   logic [31:0]   sec_q, sec_d;
   logic [3:0]    sacq_q, sacq_d;
   logic [11:0]   sms_q, sms_d;
   logic [31:0]   ssec_q, ssec_d;
   logic          svld_q, svld_d;
   logic          mst_q, mst_d;
   logic          pps_q, pps_d;
   logic          lerr_q, lerr_d;

   logic tick;
   logic acq_ok;
   logic ms_ok;

   assign tick   = enable && (pre_q == PRE_LAST);
   // Widened compares so TICKS_PER_MS=16 and MS_PER_SEC=4096 are representable.
   assign acq_ok = {1'b0, load_acq} < 5'(TICKS_PER_MS);
   assign ms_ok  = {1'b0, load_ms} < 13'(MS_PER_SEC);

   always_comb begin
      pre_d  = pre_q;
      acq_d  = acq_q;
      ms_d   = ms_q;
      sec_d  = sec_q;
      mst_d  = 1'b0;
      pps_d  = 1'b0;
      lerr_d = 1'b0;
      if (load) begin
         pre_d  = '0;
         acq_d  = acq_ok ? load_acq : 4'd0;
         ms_d   = ms_ok ? load_ms : 12'd0;
         sec_d  = load_sec;
         lerr_d = !(acq_ok && ms_ok);
      end else if (enable) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
         if (tick) begin
            if (acq_q == ACQ_LAST) begin
               acq_d = 4'd0;
               mst_d = 1'b1;
               if (ms_q == MS_LAST) begin
                  ms_d  = 12'd0;
                  pps_d = 1'b1;
                  sec_d = sec_q + 32'd1;
               end else begin
                  ms_d = ms_q + 12'd1;
               end
            end else begin
               acq_d = acq_q + 4'd1;
            end
         end
      end
   end

   // Snapshot samples the pre-edge live values, so it is coherent even across a carry.
   always_comb begin
      sacq_d = sacq_q;
      sms_d  = sms_q;
      ssec_d = ssec_q;
      svld_d = snap;
      if (snap) begin
         sacq_d = acq_q;
         sms_d  = ms_q;
         ssec_d = sec_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q  <= '0;
         acq_q  <= '0;
         ms_q   <= '0;
         sec_q  <= '0;
         sacq_q <= '0;
         sms_q  <= '0;
         ssec_q <= '0;
         svld_q <= 1'b0;
         mst_q  <= 1'b0;
         pps_q  <= 1'b0;
         lerr_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         acq_q  <= acq_d;
         ms_q   <= ms_d;
         sec_q  <= sec_d;
         sacq_q <= sacq_d;
         sms_q  <= sms_d;
         ssec_q <= ssec_d;
         svld_q <= svld_d;
         mst_q  <= mst_d;
         pps_q  <= pps_d;
         lerr_q <= lerr_d;
      end
   end

   assign acqurate_stamp    = acq_q;
   assign millisecond_stamp = ms_q;
   assign second_stamp      = sec_q;
   assign snap_acq          = sacq_q;
   assign snap_ms           = sms_q;
   assign snap_sec          = ssec_q;
   assign snap_valid        = svld_q;
   assign ms_tick           = mst_q;
   assign pps               = pps_q;
   assign load_err          = lerr_q;

endmodule
